// File: rtl/dataout_uart_tx.sv
// Serialises every change of the CPU debug byte onto an 8N1 UART line, LSB first.
// A small circular FIFO absorbs bursts; bytes arriving while it is full are dropped and flagged.
module dataout_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    data_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    prev_q, prev_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic push_req, push_ok, pop, full, baud_last;

  // FIFO bookkeeping; a pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    push_req   = (data_i != prev_q);
    pop        = (state_q == S_IDLE) && (count_q != '0);
    full       = (count_q == COUNT_FULL);
    push_ok    = push_req && (!full || pop);
    prev_d     = data_i;
    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    overflow_d = overflow_q | (push_req & ~push_ok);
    count_d    = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    baud_last = (baud_q == BAUD_LAST);
    baud_d    = baud_last ? '0 : baud_q + BW'(1);
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (baud_last) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (state_d != state_q) begin
      baud_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q     <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      prev_q     <= prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // Storage needs no reset: validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign overflow_o   = overflow_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_dataout_uart_tx.sv
// Bench for dataout_uart_tx: a UART line monitor decodes frames and compares them
// against a queue of bytes expected at the moment each change is driven.
module tb_dataout_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       tx_o;
  logic       busy_o;
  logic       overflow_o;
  logic [2:0] fifo_count_o;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [7:0] exp_q[$];

  dataout_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o),
    .fifo_count_o(fifo_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_data(input logic [7:0] b, input bit will_send);
    data_i = b;
    if (will_send) exp_q.push_back(b);
  endtask

  // Expected line samples for a whole frame, index 0 = first start-bit cycle.
  function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] b);
    logic [9:0]       f;
    logic [FRAME-1:0] r;
    f = {1'b1, b, 1'b0};
    r = '0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < CPB; j++)
        r[i*CPB + j] = f[i];
    return r;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 3000) begin
      step();
      n++;
    end
    chk_eq("drain_timeout", exp_q.size(), 0);
    step();
    step();
  endtask

  initial begin : monitor
    logic [FRAME-1:0] samp;
    logic [7:0]       e;
    bit               aborted;
    int               busy_lo;
    forever begin
      @(negedge clk_i);
      if (!rst_i && tx_o === 1'b0) begin
        aborted = 1'b0;
        busy_lo = 0;
        samp    = '0;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk_i);
          if (rst_i) aborted = 1'b1;
          samp[k] = tx_o;
          if (busy_o !== 1'b1) busy_lo++;
        end
        if (!aborted) begin
          frames++;
          chk_eq("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk_eq($sformatf("frame_bits_%02h", e), samp, frame_bits(e));
          end
          chk_eq("frame_busy", busy_lo, 0);
          @(negedge clk_i);
          chk_eq("frame_gap", {busy_o, tx_o}, 2'b01);
        end
      end
    end
  end

  initial begin : timeout
    #300000;
    errors++;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : main
    int f0, bad, n;

    // Reset state, asserted asynchronously before any clock edge
    #1 rst_i = 1'b1;
    #1 chk_eq("reset_outputs", {tx_o, busy_o, overflow_o, fifo_count_o}, 6'b100000);
    step(); step(); step();
    rst_i = 1'b0;

    // Idle after reset with data 0x00: nothing is sent
    bad = 0;
    repeat (100) begin
      step();
      if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    chk_eq("idle_quiet", bad, 0);
    chk_eq("idle_frames", frames, 0);

    // Single byte 0xA5
    set_data(8'hA5, 1'b1);
    step();
    chk_eq("a5_push_tx", tx_o, 1'b1);
    chk_eq("a5_push_cnt", fifo_count_o, 3'd1);
    step();
    chk_eq("a5_start_tx", tx_o, 1'b0);
    chk_eq("a5_pop_cnt", fifo_count_o, 3'd0);
    n = 1;
    while (busy_o && n < 200) begin
      step();
      if (busy_o) n++;
    end
    chk_eq("a5_busy_cycles", n, FRAME);
    drain();
    chk_eq("a5_frames", frames, 1);

    // Burst of three consecutive changes
    f0 = frames;
    set_data(8'h11, 1'b1); step();
    set_data(8'h22, 1'b1); step();
    set_data(8'h33, 1'b1); step();
    chk_eq("burst_peak_cnt", fifo_count_o, 3'd2);
    drain();
    chk_eq("burst_frames", frames - f0, 3);
    chk_eq("burst_no_ovf", overflow_o, 1'b0);

    // Overflow: seven changes, first sent, four queued, two dropped
    f0 = frames;
    for (int i = 0; i < 7; i++) begin
      set_data(8'h41 + 8'(i), i < 5);
      step();
    end
    chk_eq("ovf_set", overflow_o, 1'b1);
    chk_eq("ovf_full_cnt", fifo_count_o, 3'd4);
    drain();
    chk_eq("ovf_sticky", overflow_o, 1'b1);
    chk_eq("ovf_frames", frames - f0, 5);

    // Asynchronous reset clears the sticky flag without a clock edge
    data_i = 8'h00;
    #2 rst_i = 1'b1;
    #1 chk_eq("reset_mid_sim", {tx_o, busy_o, overflow_o, fifo_count_o}, 6'b100000);
    exp_q.delete();
    step();
    rst_i = 1'b0;

    // Full FIFO: a push on the same edge IDLE pops is accepted
    f0 = frames;
    set_data(8'h60, 1'b1); step();
    step();
    set_data(8'h61, 1'b1); step();
    set_data(8'h62, 1'b1); step();
    set_data(8'h63, 1'b1); step();
    set_data(8'h64, 1'b1); step();
    chk_eq("full_cnt", fifo_count_o, 3'd4);
    n = 0;
    while (busy_o && n < 100) begin
      step();
      n++;
    end
    chk_eq("full_reach_idle", busy_o, 1'b0);
    chk_eq("full_at_idle_cnt", fifo_count_o, 3'd4);
    set_data(8'h65, 1'b1);
    step();
    chk_eq("pushpop_cnt", fifo_count_o, 3'd4);
    chk_eq("pushpop_no_ovf", overflow_o, 1'b0);
    chk_eq("pushpop_busy", busy_o, 1'b1);
    drain();
    chk_eq("pushpop_frames", frames - f0, 6);
    chk_eq("pushpop_ovf_end", overflow_o, 1'b0);

    // Reset during bit 3 of a 0x5A frame with two bytes queued
    f0 = frames;
    set_data(8'h5A, 1'b1); step();
    step();
    set_data(8'h01, 1'b0); step();
    set_data(8'h02, 1'b0); step();
    chk_eq("mid_queued_cnt", fifo_count_o, 3'd2);
    repeat (15) step();
    chk_eq("mid_busy", busy_o, 1'b1);
    data_i = 8'h00;
    #2 rst_i = 1'b1;
    #1 chk_eq("reset_mid_frame", {tx_o, busy_o, overflow_o, fifo_count_o}, 6'b100000);
    exp_q.delete();
    step();
    rst_i = 1'b0;
    bad = 0;
    repeat (60) begin
      step();
      if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    chk_eq("post_reset_quiet", bad, 0);
    chk_eq("post_reset_frames", frames - f0, 0);
    set_data(8'h3C, 1'b1);
    drain();
    chk_eq("post_reset_resume", frames - f0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
